add_sub_seq: RTL and testbench
==============================

# add_sub_seq

Multi-cycle sequencer that performs WIDTH-bit addition or subtraction by driving one 4-bit nibble adder for WIDTH/4 cycles, low nibble first, chaining carry through a register. It sits between a requester and a consumer on valid/ready handshakes. It replaces a full-width combinational adder/subtractor wherever area matters more than latency.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of 4 and at least 4.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- mode  input  1  0 = add (A+B), 1 = subtract (A-B); sampled only on the accept edge.
- out_valid  output  1  result available (high only in DONE).
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  sum or difference modulo 2^WIDTH.
- carry  output  1  final carry-out; for subtract, 1 = no borrow (A >= B unsigned).
- zero  output  1  result == 0.

## Operation
- NIBS = WIDTH/4. State machine: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid=1:
  - capture a into op_a;
  - capture b into op_b, or ~b if mode=1;
  - set c_reg = mode, so subtract is A + ~B + 1;
  - clear cnt; go to RUN.
- RUN: each cycle:
  - nibble adder computes op_a[3:0] + op_b[3:0] + c_reg;
  - the sum nibble shifts into the top of the result register, which shifts right by 4;
  - op_a and op_b shift right by 4;
  - c_reg takes the nibble carry-out; cnt increments.
  - When cnt == NIBS-1, go to DONE on this edge.
- DONE: out_valid=1. result, carry (= c_reg) and zero are held stable until the handshake.
  - On out_ready=1, go to IDLE.
  - result, carry and zero keep their values in IDLE until the next accept.
- in_valid is ignored outside IDLE. a, b and mode may change freely after the accept edge.
- Arithmetic is unsigned modulo 2^WIDTH. No signed overflow flag is provided.
- Reset, in any state including mid-RUN: state=IDLE, cnt=0, c_reg=0, result=0, carry=0, zero=1, in_ready=1 on the cycle after the reset edge, out_valid=0. An in-flight operation is discarded with no output.

## Timing
- Accept edge = rising edge with in_ready & in_valid.
- out_valid rises exactly NIBS cycles after the accept edge (4 cycles for WIDTH=16, 1 cycle for WIDTH=4).
- Result handshake = edge with out_valid & out_ready.
- in_ready rises one cycle after the result handshake, so the minimum issue interval is NIBS+2 cycles.
- There are no combinational paths from in_valid or out_ready to any output. All outputs are registered or decoded from state only.
- out_ready held low keeps DONE, and holds all outputs, indefinitely.

## Structure
- Shared package add_sub_pkg holds:
  - NIB_W = 4;
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the mode encodings (MODE_ADD=0, MODE_SUB=1).
- Sub-module nibble_add: purely combinational. Ports a[3:0], b[3:0], cin -> sum[3:0], cout. One instance only.
- cnt width is $clog2(NIBS), minimum 1 bit.

## Test plan
- WIDTH=16, add: A=0x1234, B=0x0FFF -> result=0x2233, carry=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- Subtract: A=0x5000, B=0x0001 -> 0x4FFF, carry=1. Then subtract A=0x0002, B=0x0008 -> 0xFFFA, carry=0.
- Add: A=0xFFFF, B=0x0001 -> result=0x0000, carry=1, zero=1. Verifies the carry ripples through all 4 nibbles.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and changing a, b -> outputs stable, in_ready=0, no new accept. Release out_ready -> in_ready=1 on the next cycle.
- Reset mid-op: assert rst when cnt=2 -> next cycle state IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=1. A following add of 0x0001+0x0001 returns 0x0002.
- WIDTH=4 build: A=4'b0101, B=4'b0011, mode=0 -> 4'b1000, carry=0, 1 cycle latency. Then mode=1 -> 4'b0010, carry=1.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// nibble width, FSM state encoding and operation mode encodings.
package add_sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_seq_if.sv
// Request/result bus for add_sub_seq. The slave modport is the sequencer side,
// and the master modport is the requester/consumer side.
interface add_sub_seq_if #(
    parameter int WIDTH = 16
);
    // Both channels use valid/ready handshaking. A transfer happens on a rising
    // edge where valid and ready are both high. Valid is not withdrawn and its
    // payload is not changed before that edge. Ready never depends
    // combinationally on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, carry, zero
    );

endinterface

// File: rtl/add_sub_seq_nibble_add.sv
// Combinational 4-bit adder with carry in and carry out. It is the only
// arithmetic element in the sequencer.
module nibble_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};

endmodule

// File: rtl/add_sub_seq.sv
// WIDTH-bit add/subtract built from one nibble adder. It processes one nibble
// per cycle, low nibble first, and chains the carry through c_reg.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    add_sub_seq_if.slave bus,
    output state_t       dbg_state
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [WIDTH-1:0]       op_a, op_a_n;
    logic [WIDTH-1:0]       op_b, op_b_n;
    logic [WIDTH-1:0]       res, res_n;
    logic                   c_reg, c_n;
    logic [NIB_W-1:0]       nib_sum;
    logic                   nib_cout;
    logic [WIDTH+NIB_W-1:0] res_shift;

    nibble_add u_nib (
        .a    (op_a[NIB_W-1:0]),
        .b    (op_b[NIB_W-1:0]),
        .cin  (c_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // The new nibble enters at the top, so after NIBS shifts the low nibble
    // has moved down to bit 0. This stays valid when WIDTH == NIB_W.
    assign res_shift = {nib_sum, res};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_a_n  = op_a;
        op_b_n  = op_b;
        res_n   = res;
        c_n     = c_reg;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_n  = bus.a;
                    op_b_n  = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                    c_n     = bus.mode;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                res_n  = res_shift[WIDTH+NIB_W-1:NIB_W];
                op_a_n = op_a >> NIB_W;
                op_b_n = op_b >> NIB_W;
                c_n    = nib_cout;
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(NIBS - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            c_reg <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            res   <= res_n;
            c_reg <= c_n;
        end
    end

    // Every output is driven only by state or by registers.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res;
    assign bus.carry     = c_reg;
    assign bus.zero      = (res == '0);
    assign dbg_state     = state;

endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq. It covers a 16-bit and a 4-bit build,
// using a scoreboard queue of expected results.
module tb_add_sub_seq;
    import add_sub_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg16, dbg4;

    int n_tests = 0;
    int n_fail  = 0;

    // Each entry is {zero, carry, result[15:0]}.
    logic [17:0] exp_q[$];
    logic [15:0] last_res;
    logic        last_c;
    logic        last_z;

    add_sub_seq_if #(.WIDTH(16)) bus16();
    add_sub_seq_if #(.WIDTH(4))  bus4();

    add_sub_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16), .dbg_state(dbg16));
    add_sub_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4),  .dbg_state(dbg4));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ov(input bit w4);
        return w4 ? bus4.out_valid : bus16.out_valid;
    endfunction

    function automatic logic get_ir(input bit w4);
        return w4 ? bus4.in_ready : bus16.in_ready;
    endfunction

    function automatic logic [31:0] get_res(input bit w4);
        return w4 ? {28'd0, bus4.result} : {16'd0, bus16.result};
    endfunction

    function automatic logic get_c(input bit w4);
        return w4 ? bus4.carry : bus16.carry;
    endfunction

    function automatic logic get_z(input bit w4);
        return w4 ? bus4.zero : bus16.zero;
    endfunction

    task automatic drive_in(input bit w4, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic m);
        if (w4) begin
            bus4.in_valid = v; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.mode = m;
        end else begin
            bus16.in_valid = v; bus16.a = a; bus16.b = b; bus16.mode = m;
        end
    endtask

    task automatic set_ordy(input bit w4, input logic r);
        if (w4) bus4.out_ready = r;
        else    bus16.out_ready = r;
    endtask

    // Issue one operation, check its latency and result, optionally stall in
    // DONE for `hold` cycles, then complete the result handshake.
    task automatic run_op(input bit w4, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input int hold);
        int          cyc;
        int          nibs;
        logic [15:0] mask;
        logic [16:0] full;
        logic [15:0] r;
        logic        c;
        logic [17:0] e;
        logic [31:0] snap_r;
        logic        snap_c, snap_z;
        mask = w4 ? 16'h000F : 16'hFFFF;
        nibs = w4 ? 1 : 4;
        cyc = 0;
        while (!get_ir(w4) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!get_ir(w4)) begin
            check("in_ready_wait", 32'(get_ir(w4)), 32'd1);
            return;
        end
        drive_in(w4, 1'b1, a, b, m);
        if (m) full = {1'b0, a & mask} + {1'b0, ~b & mask} + 17'd1;
        else   full = {1'b0, a & mask} + {1'b0, b & mask};
        r = full[15:0] & mask;
        c = w4 ? full[4] : full[16];
        exp_q.push_back({(r == 16'd0), c, r});
        @(posedge clk); #1;
        drive_in(w4, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!get_ov(w4) && cyc < 20);
        check("latency", cyc, nibs);
        snap_r = get_res(w4);
        snap_c = get_c(w4);
        snap_z = get_z(w4);
        for (int i = 0; i < hold; i++) begin
            drive_in(w4, 1'(i % 2 == 0), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            check("bp_out_valid", 32'(get_ov(w4)), 32'd1);
            check("bp_in_ready", 32'(get_ir(w4)), 32'd0);
            check("bp_result", get_res(w4), snap_r);
            check("bp_carry", 32'(get_c(w4)), 32'(snap_c));
            check("bp_zero", 32'(get_z(w4)), 32'(snap_z));
        end
        drive_in(w4, 1'b0, 16'd0, 16'd0, 1'b0);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("result", get_res(w4), {16'd0, e[15:0]});
        check("carry", 32'(get_c(w4)), 32'(e[16]));
        check("zero", 32'(get_z(w4)), 32'(e[17]));
        last_res = get_res(w4) & mask;
        last_c   = get_c(w4);
        last_z   = get_z(w4);
        set_ordy(w4, 1'b1);
        @(posedge clk); #1;
        set_ordy(w4, 1'b0);
        check("hs_in_ready", 32'(get_ir(w4)), 32'd1);
        check("hs_out_valid", 32'(get_ov(w4)), 32'd0);
        check("idle_result_hold", get_res(w4), {16'd0, e[15:0]});
    endtask

    initial begin
        drive_in(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        drive_in(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_state", 32'(dbg16), 32'(IDLE));
        check("rst_in_ready", 32'(bus16.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("rst_result", 32'(bus16.result), 32'd0);
        check("rst_carry", 32'(bus16.carry), 32'd0);
        check("rst_zero", 32'(bus16.zero), 32'd1);
        check("rst4_state", 32'(dbg4), 32'(IDLE));

        run_op(1'b0, 16'h1234, 16'h0FFF, MODE_ADD, 0);
        check("plan_add_res", 32'(last_res), 32'h2233);
        check("plan_add_c", 32'(last_c), 32'd0);
        check("plan_add_z", 32'(last_z), 32'd0);

        run_op(1'b0, 16'h5000, 16'h0001, MODE_SUB, 0);
        check("plan_sub1_res", 32'(last_res), 32'h4FFF);
        check("plan_sub1_c", 32'(last_c), 32'd1);

        run_op(1'b0, 16'h0002, 16'h0008, MODE_SUB, 0);
        check("plan_sub2_res", 32'(last_res), 32'hFFFA);
        check("plan_sub2_c", 32'(last_c), 32'd0);

        run_op(1'b0, 16'hFFFF, 16'h0001, MODE_ADD, 0);
        check("plan_ripple_res", 32'(last_res), 32'h0000);
        check("plan_ripple_c", 32'(last_c), 32'd1);
        check("plan_ripple_z", 32'(last_z), 32'd1);

        run_op(1'b0, 16'hA5A5, 16'h1111, MODE_SUB, 3);

        // Abort an operation two nibbles in.
        drive_in(1'b0, 1'b1, 16'h1111, 16'h2222, MODE_ADD);
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, MODE_SUB);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_run_state", 32'(dbg16), 32'(RUN));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_state", 32'(dbg16), 32'(IDLE));
        check("mid_rst_in_ready", 32'(bus16.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus16.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus16.result), 32'd0);
        check("mid_rst_carry", 32'(bus16.carry), 32'd0);
        check("mid_rst_zero", 32'(bus16.zero), 32'd1);
        run_op(1'b0, 16'h0001, 16'h0001, MODE_ADD, 0);
        check("post_rst_res", 32'(last_res), 32'h0002);

        run_op(1'b0, 16'h0000, 16'h0000, MODE_SUB, 0);
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end

        run_op(1'b1, 16'h0005, 16'h0003, MODE_ADD, 0);
        check("w4_add_res", 32'(last_res), 32'h8);
        check("w4_add_c", 32'(last_c), 32'd0);
        run_op(1'b1, 16'h0005, 16'h0003, MODE_SUB, 1);
        check("w4_sub_res", 32'(last_res), 32'h2);
        check("w4_sub_c", 32'(last_c), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
